pwm_triangle_modulator: RTL and testbench
=========================================

Name: pwm_triangle_modulator

Overview:
Downstream consumer of the frequency trigger's one-cycle clock-enable pulse (freq_trig).
- Each trigger pulse advances a PWM carrier counter.
- Duty cycle is swept up and down in a triangle pattern, one step per PWM period, which gives a "breathing" PWM on pwm_out.
- Runs on the same clk_in as the trigger. No clock-domain crossing.

Parameters:
CNT_W, 8, width of carrier counter, duty and step values
TOP, 8'd99, carrier counter terminal value; period = TOP+1 trigger pulses; requires TOP <= 2^CNT_W-2

Ports:
clk_in  input  1  system clock, shared with the frequency trigger
rst_n  input  1  asynchronous active-low reset
freq_trig_in  input  1  one-clk_in-cycle clock-enable pulse from the frequency trigger
en_in  input  1  modulator enable; 0 = idle
duty_step_in  input  CNT_W  duty increment/decrement applied per PWM period
duty_max_in  input  CNT_W  upper duty limit; values above TOP+1 are clamped to TOP+1
pwm_out  output  1  modulated PWM output
period_end_out  output  1  one-cycle pulse at each carrier wrap
dir_out  output  1  ramp direction: 0 = rising (UP), 1 = falling (DOWN)

Behaviour:
- Reset (async, rst_n=0):
  - cnt=0, duty_act=0, state=UP.
  - pwm_out=0, period_end_out=0, dir_out=0.
  - Effect is immediate, regardless of clk_in.
- Carrier counter:
  - Advances only when en_in=1 and freq_trig_in=1.
  - Counts 0..TOP, then wraps from TOP to 0.
  - With no trigger, all state holds.
- PWM compare:
  - pwm_out is registered: pwm_out <= en_in & (cnt < duty_act).
  - Latency is 1 clk_in after cnt/duty_act change.
  - duty_act=0 gives constant 0. duty_act=TOP+1 gives constant 1.
- Period boundary (cnt==TOP and trigger and en_in):
  - period_end_out=1 for exactly the following clk_in cycle.
  - duty_act is updated from the ramp FSM.
  - duty_step_in and duty_max_in are sampled only here (shadow behaviour). Mid-period changes have no effect until the next wrap.
- Ramp FSM, evaluated only at the period boundary. Arithmetic is in CNT_W+1 bits, so there is no wrap-around. Let m = min(duty_max_in, TOP+1).
  - UP: if duty_act + step >= m, then duty_act <= m, state <= DOWN. Otherwise duty_act <= duty_act + step.
  - DOWN: if duty_act <= step, then duty_act <= 0, state <= UP. Otherwise duty_act <= duty_act - step.
  - duty_act > m while in DOWN (duty_max lowered): duty_act <= m, stay in DOWN.
  - step=0: duty_act frozen, state unchanged.
  - m=0: duty_act stays 0. State toggles UP->DOWN->UP on successive boundaries.
- dir_out = (state==DOWN), registered alongside state.
- en_in=0:
  - Synchronously clears cnt to 0 and forces pwm_out to 0 next cycle.
  - duty_act and state hold.
  - If en_in=0 and freq_trig_in=1 occur together, en_in wins: no advance and no period_end.
- Re-enable: carrier restarts from cnt=0 with the held duty_act.
- freq_trig_in asserted on consecutive cycles: each cycle counts as one step (no edge detection).

Decomposition:
- Shared package pwm_pkg holds:
  - the CNT_W default;
  - the ramp state encoding (UP=1'b0, DOWN=1'b1);
  - a min/clamp function for duty limits.
- One sub-module, duty_ramp:
  - contains the triangle FSM and duty_act register;
  - inputs: clk_in, rst_n, boundary strobe, step, max;
  - outputs: duty_act, dir.
- Top level holds the carrier counter, compare, and period_end register.

Test Plan:
1. TOP=9, duty_step=2, duty_max=10, trigger every clk.
   - Over 7 periods, duty_act takes 0,2,4,6,8,10,8.
   - dir_out rises at the 10 transition.
   - pwm_out high for duty_act of the 10 counts each period.
2. Reset asserted mid-period (cnt=5, duty_act=6, DOWN).
   - All outputs are 0 immediately, without a clock edge.
   - After release, the first period has pwm_out constantly 0 and dir_out=0.
3. Trigger every 4th clk (frequency-trigger-like), TOP=9.
   - period_end_out pulses exactly every 40 clk_in, each pulse 1 cycle wide.
   - cnt never advances without a trigger.
4. duty_max lowered from 10 to 4 mid-period while duty_act=8 (DOWN).
   - No change before the wrap.
   - At the wrap, duty_act becomes 4 and dir_out stays 1.
5. en_in=0 coincident with trigger at cnt=TOP.
   - No period_end_out, cnt=0, pwm_out=0 next cycle, duty_act unchanged.
   - After re-enable, counting resumes from 0.
6. duty_max=200 (>TOP+1=100, default TOP), step=60.
   - duty_act sequence 0,60,100,40,0,60.
   - pwm_out is constant 1 for the whole period at duty_act=100.

Source files
------------

// File: rtl/pwm_triangle_modulator_pkg.sv
// Shared definitions for the triangle-swept PWM modulator: default widths,
// ramp state encoding and the duty-limit clamp.
package pwm_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic {
    RAMP_UP   = 1'b0,
    RAMP_DOWN = 1'b1
  } ramp_state_e;

  // Limit a requested duty ceiling to what the carrier can actually express.
  function automatic int unsigned clamp_max(input int unsigned val, input int unsigned lim);
    return (val > lim) ? lim : val;
  endfunction

endpackage

// File: rtl/pwm_triangle_modulator_if.sv
// Control/status bundle between the modulator and whoever drives it.
interface pwm_triangle_modulator_if
  import pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic             freq_trig_in;
  logic             en_in;
  logic [CNT_W-1:0] duty_step_in;
  logic [CNT_W-1:0] duty_max_in;
  logic             pwm_out;
  logic             period_end_out;
  logic             dir_out;

  modport master (
    output freq_trig_in, en_in, duty_step_in, duty_max_in,
    input  pwm_out, period_end_out, dir_out
  );

  modport slave (
    input  freq_trig_in, en_in, duty_step_in, duty_max_in,
    output pwm_out, period_end_out, dir_out
  );

endinterface

// File: rtl/pwm_triangle_modulator_duty_ramp.sv
// Triangle duty sweep: moves duty_act by one step per PWM period, bouncing
// between 0 and the clamped ceiling. Step and ceiling are only looked at on
// the period boundary strobe.
module duty_ramp
  import pwm_pkg::*;
#(
  parameter int               CNT_W = CNT_W_DEF,
  parameter logic [CNT_W-1:0] TOP   = CNT_W'(99)
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             boundary,
  input  logic [CNT_W-1:0] step,
  input  logic [CNT_W-1:0] max,
  output logic [CNT_W-1:0] duty_act,
  output logic             dir
);

  localparam int          W1   = CNT_W + 1;
  localparam int unsigned FULL = int'(TOP) + 1;

  ramp_state_e      state, state_nxt;
  logic [CNT_W-1:0] duty_nxt;
  logic [W1-1:0]    duty_w, step_w, lim, sum_w, diff_w;

  // Arithmetic one bit wider than the counter so up-steps never wrap.
  assign duty_w = {1'b0, duty_act};
  assign step_w = {1'b0, step};
  assign lim    = W1'(clamp_max(32'(max), FULL));
  assign sum_w  = duty_w + step_w;
  assign diff_w = duty_w - step_w;

  // State and duty registers.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RAMP_UP;
      duty_act <= '0;
    end else begin
      state    <= state_nxt;
      duty_act <= duty_nxt;
    end
  end

  // Next duty/direction, evaluated only at the period boundary; a zero step freezes the sweep.
  always_comb begin
    state_nxt = state;
    duty_nxt  = duty_act;
    if (boundary && (step != '0)) begin
      case (state)
        RAMP_UP: begin
          if (sum_w >= lim) begin
            duty_nxt  = lim[CNT_W-1:0];
            state_nxt = RAMP_DOWN;
          end else begin
            duty_nxt  = sum_w[CNT_W-1:0];
          end
        end
        RAMP_DOWN: begin
          if (duty_w > lim) begin
            // Ceiling was lowered under us: snap down and keep falling.
            duty_nxt  = lim[CNT_W-1:0];
          end else if (duty_w <= step_w) begin
            duty_nxt  = '0;
            state_nxt = RAMP_UP;
          end else begin
            duty_nxt  = diff_w[CNT_W-1:0];
          end
        end
        default: begin
          state_nxt = RAMP_UP;
          duty_nxt  = '0;
        end
      endcase
    end
  end

  // Direction flag straight from the state register.
  always_comb begin
    dir = (state == RAMP_DOWN);
  end

endmodule

// File: rtl/pwm_triangle_modulator.sv
// Breathing PWM: a trigger-driven carrier counter compared against a duty
// value that the ramp sub-block sweeps up and down once per period.
module pwm_triangle_modulator
  import pwm_pkg::*;
#(
  parameter int               CNT_W = CNT_W_DEF,
  parameter logic [CNT_W-1:0] TOP   = CNT_W'(99)
) (
  input  logic                        clk_in,
  input  logic                        rst_n,
  pwm_triangle_modulator_if.slave     bus
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] duty_act;
  logic             advance;
  logic             boundary;
  logic             dir;
  logic             pwm_p1;
  logic             period_end_p1;

  // Enable dominates the trigger: no advance and no boundary while idle.
  assign advance  = bus.en_in & bus.freq_trig_in;
  assign boundary = advance & (cnt == TOP);

  // Carrier counter: 0..TOP on trigger pulses, cleared while disabled.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!bus.en_in) begin
      cnt <= '0;
    end else if (advance) begin
      cnt <= boundary ? '0 : cnt + CNT_W'(1);
    end
  end

  duty_ramp #(
    .CNT_W (CNT_W),
    .TOP   (TOP)
  ) u_ramp (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .boundary (boundary),
    .step     (bus.duty_step_in),
    .max      (bus.duty_max_in),
    .duty_act (duty_act),
    .dir      (dir)
  );

  // Registered compare and wrap pulse, one cycle behind the counter.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      pwm_p1        <= 1'b0;
      period_end_p1 <= 1'b0;
    end else begin
      pwm_p1        <= bus.en_in & (cnt < duty_act);
      period_end_p1 <= boundary;
    end
  end

  assign bus.pwm_out        = pwm_p1;
  assign bus.period_end_out = period_end_p1;
  assign bus.dir_out        = dir;

endmodule

// File: tb/tb_pwm_triangle_modulator.sv
// Directed bench: a TOP=9 instance for most scenarios and a default TOP=99
// instance for the clamp-to-full-duty sweep.
module tb_pwm_triangle_modulator;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  pwm_triangle_modulator_if #(.CNT_W(8)) ifa ();
  pwm_triangle_modulator_if #(.CNT_W(8)) ifb ();

  pwm_triangle_modulator #(.CNT_W(8), .TOP(8'd9)) dut_a (
    .clk_in (clk),
    .rst_n  (rst_n),
    .bus    (ifa)
  );

  pwm_triangle_modulator #(.CNT_W(8), .TOP(8'd99)) dut_b (
    .clk_in (clk),
    .rst_n  (rst_n),
    .bus    (ifb)
  );

  typedef struct {
    bit         big;       // 0: TOP=9 instance, 1: TOP=99 instance
    logic [7:0] step;
    logic [7:0] max;
    int         chg_at;    // sample index at which max is rewritten (-1 = never)
    logic [7:0] chg_max;
    int         exp_duty;  // pwm high cycles expected in this period
    bit         exp_dir;   // dir_out expected during this period
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Run one full carrier period (trigger every clock) and check duty, dir and wrap pulse.
  task automatic run_vec(input vec_t v, input string tag);
    int len;
    int hi;
    int pe;
    bit first_dir;
    bit last_pe;
    len = v.big ? 100 : 10;
    hi = 0;
    pe = 0;
    first_dir = 1'b0;
    last_pe = 1'b0;
    if (v.big) begin
      ifb.duty_step_in = v.step;
      ifb.duty_max_in  = v.max;
    end else begin
      ifa.duty_step_in = v.step;
      ifa.duty_max_in  = v.max;
    end
    for (int i = 0; i < len; i++) begin
      if (i == v.chg_at) begin
        if (v.big) ifb.duty_max_in = v.chg_max;
        else       ifa.duty_max_in = v.chg_max;
      end
      tick();
      if (v.big) begin
        hi += int'(ifb.pwm_out);
        pe += int'(ifb.period_end_out);
        if (i == 0) first_dir = ifb.dir_out;
        if (i == len - 1) last_pe = ifb.period_end_out;
      end else begin
        hi += int'(ifa.pwm_out);
        pe += int'(ifa.period_end_out);
        if (i == 0) first_dir = ifa.dir_out;
        if (i == len - 1) last_pe = ifa.period_end_out;
      end
    end
    check({tag, "_duty"},   32'(hi),        32'(v.exp_duty));
    check({tag, "_dir"},    32'(first_dir), 32'(v.exp_dir));
    check({tag, "_pe_cnt"}, 32'(pe),        32'd1);
    check({tag, "_pe_end"}, 32'(last_pe),   32'd1);
  endtask

  initial begin
    int hi;
    int pe;
    int pulses[$];

    // TOP=9, step 2, max 10: rising sweep, turn at 10
    vecs.push_back('{1'b0, 8'd2, 8'd10, -1, 8'd0, 0,  1'b0});
    vecs.push_back('{1'b0, 8'd2, 8'd10, -1, 8'd0, 2,  1'b0});
    vecs.push_back('{1'b0, 8'd2, 8'd10, -1, 8'd0, 4,  1'b0});
    vecs.push_back('{1'b0, 8'd2, 8'd10, -1, 8'd0, 6,  1'b0});
    vecs.push_back('{1'b0, 8'd2, 8'd10, -1, 8'd0, 8,  1'b0});
    vecs.push_back('{1'b0, 8'd2, 8'd10, -1, 8'd0, 10, 1'b1});
    vecs.push_back('{1'b0, 8'd2, 8'd10, -1, 8'd0, 8,  1'b1});
    // first period after a mid-period reset
    vecs.push_back('{1'b0, 8'd2, 8'd10, -1, 8'd0, 0,  1'b0});
    // climb again, lower max to 4 mid-period at duty 8
    vecs.push_back('{1'b0, 8'd2, 8'd10, -1, 8'd0, 2,  1'b0});
    vecs.push_back('{1'b0, 8'd2, 8'd10, -1, 8'd0, 4,  1'b0});
    vecs.push_back('{1'b0, 8'd2, 8'd10, -1, 8'd0, 6,  1'b0});
    vecs.push_back('{1'b0, 8'd2, 8'd10, -1, 8'd0, 8,  1'b0});
    vecs.push_back('{1'b0, 8'd2, 8'd10, -1, 8'd0, 10, 1'b1});
    vecs.push_back('{1'b0, 8'd2, 8'd10, 5,  8'd4, 8,  1'b1});
    vecs.push_back('{1'b0, 8'd2, 8'd4,  -1, 8'd0, 4,  1'b1});
    vecs.push_back('{1'b0, 8'd2, 8'd4,  -1, 8'd0, 2,  1'b1});
    vecs.push_back('{1'b0, 8'd2, 8'd4,  -1, 8'd0, 0,  1'b0});
    vecs.push_back('{1'b0, 8'd2, 8'd4,  -1, 8'd0, 2,  1'b0});
    // after the en_in=0 abort at cnt=TOP: duty 4 held, then continue down
    vecs.push_back('{1'b0, 8'd2, 8'd4,  -1, 8'd0, 4,  1'b1});
    vecs.push_back('{1'b0, 8'd2, 8'd4,  -1, 8'd0, 2,  1'b1});
    // TOP=99, max 200 clamps to 100, step 60
    vecs.push_back('{1'b1, 8'd60, 8'd200, -1, 8'd0, 0,   1'b0});
    vecs.push_back('{1'b1, 8'd60, 8'd200, -1, 8'd0, 60,  1'b0});
    vecs.push_back('{1'b1, 8'd60, 8'd200, -1, 8'd0, 100, 1'b1});
    vecs.push_back('{1'b1, 8'd60, 8'd200, -1, 8'd0, 40,  1'b1});
    vecs.push_back('{1'b1, 8'd60, 8'd200, -1, 8'd0, 0,   1'b0});
    vecs.push_back('{1'b1, 8'd60, 8'd200, -1, 8'd0, 60,  1'b0});

    rst_n = 1'b0;
    ifa.freq_trig_in = 1'b0; ifa.en_in = 1'b0; ifa.duty_step_in = 8'd2;  ifa.duty_max_in = 8'd10;
    ifb.freq_trig_in = 1'b0; ifb.en_in = 1'b0; ifb.duty_step_in = 8'd60; ifb.duty_max_in = 8'd200;
    #2;
    check("rst_pwm_a", 32'(ifa.pwm_out),        32'd0);
    check("rst_pe_a",  32'(ifa.period_end_out), 32'd0);
    check("rst_dir_a", 32'(ifa.dir_out),        32'd0);
    check("rst_pwm_b", 32'(ifb.pwm_out),        32'd0);
    check("rst_pe_b",  32'(ifb.period_end_out), 32'd0);
    check("rst_dir_b", 32'(ifb.dir_out),        32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic sweep
    ifa.en_in = 1'b1;
    ifa.freq_trig_in = 1'b1;
    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Async reset mid-period at cnt=5, duty 6, falling
    hi = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      hi += int'(ifa.pwm_out);
    end
    check("pre_rst_hi",  32'(hi),          32'd5);
    check("pre_rst_dir", 32'(ifa.dir_out), 32'd1);
    rst_n = 1'b0;
    #2;
    check("async_pwm", 32'(ifa.pwm_out),        32'd0);
    check("async_pe",  32'(ifa.period_end_out), 32'd0);
    check("async_dir", 32'(ifa.dir_out),        32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_vec(vecs[7], "v7");

    // Climb, lower ceiling mid-period, and sweep back down
    for (int i = 8; i < 18; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // en_in dropped together with the trigger at cnt=TOP
    hi = 0;
    pe = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      hi += int'(ifa.pwm_out);
      pe += int'(ifa.period_end_out);
    end
    check("abort_pre_hi", 32'(hi), 32'd4);
    check("abort_pre_pe", 32'(pe), 32'd0);
    ifa.en_in = 1'b0;
    tick();
    check("abort_pe",  32'(ifa.period_end_out), 32'd0);
    check("abort_pwm", 32'(ifa.pwm_out),        32'd0);
    check("abort_dir", 32'(ifa.dir_out),        32'd1);
    tick();
    check("abort_pe2", 32'(ifa.period_end_out), 32'd0);
    ifa.en_in = 1'b1;
    for (int i = 18; i < 20; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Trigger every 4th clock: wrap pulse every 40 clocks
    ifa.freq_trig_in = 1'b0;
    for (int c = 0; c < 200; c++) begin
      ifa.freq_trig_in = ((c % 4) == 0);
      tick();
      if (ifa.period_end_out) pulses.push_back(c + 1);
    end
    ifa.freq_trig_in = 1'b0;
    ifa.en_in = 1'b0;
    check("trig4_npulse", 32'(pulses.size()), 32'd5);
    if (pulses.size() > 0) check("trig4_first", 32'(pulses[0]), 32'd37);
    for (int i = 1; i < pulses.size(); i++)
      check($sformatf("trig4_gap%0d", i), 32'(pulses[i] - pulses[i-1]), 32'd40);

    // Default TOP=99 with clamped ceiling
    ifb.en_in = 1'b1;
    ifb.freq_trig_in = 1'b1;
    for (int i = 20; i < 26; i++) run_vec(vecs[i], $sformatf("v%0d", i));
    ifb.en_in = 1'b0;
    ifb.freq_trig_in = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
